// File: rtl/eight_to_twenty.sv
// ---------------------------------------------------------------------------
// eight_to_twenty
// Width gearbox: 8-word input beats in, 20-word output beats out.
// Every 5 accepted input beats (40 words) produce exactly 2 output beats.
// Word order is preserved; word 0 of the first input beat lands in the LSB
// word of the output.
//
// Optional build macro: EIGHT_TO_TWENTY_FLUSH_EN
//   When defined, adds a flush input that emits the held words as a partial,
//   zero-padded output beat, flagged by dout_partial.
//
// Ports:
//   clk          sole clock, rising edge
//   arst_n       asynchronous active-low reset
//   din          8*WORD_LEN input beat, word k at [(k+1)*WORD_LEN-1 : k*WORD_LEN]
//   din_valid    din holds a valid beat
//   din_ready    block can take din this cycle (combinational)
//   dout         20*WORD_LEN registered output beat, same packing as din
//   dout_valid   dout holds an unconsumed beat
//   dout_ready   downstream takes dout this cycle
//   flush        (flush build) emit held words as a partial beat
//   dout_partial (flush build) current dout is a flushed partial beat
//
// State table:
//   state | meaning
//   S0    | hold empty
//   S1    | hold has 8 words  (hold[7:0])
//   S2    | hold has 16 words (hold[15:0])
//   S3    | hold has 4 words  (hold[3:0])
//   S4    | hold has 12 words (hold[11:0])
// ---------------------------------------------------------------------------
module eight_to_twenty #(
    parameter int WORD_LEN = 66
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [8*WORD_LEN-1:0]  din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [20*WORD_LEN-1:0] dout,
    output logic                   dout_valid,
    input  logic                   dout_ready
`ifdef EIGHT_TO_TWENTY_FLUSH_EN
    ,
    input  logic                   flush,
    output logic                   dout_partial
`endif
);

    localparam int W = WORD_LEN;

    localparam logic [4:0] S0 = 5'b00001;
    localparam logic [4:0] S1 = 5'b00010;
    localparam logic [4:0] S2 = 5'b00100;
    localparam logic [4:0] S3 = 5'b01000;
    localparam logic [4:0] S4 = 5'b10000;

    logic [4:0]      r_state;
    logic [16*W-1:0] r_hold;
    logic [20*W-1:0] r_dout;
    logic            r_dout_valid;

    logic w_output_wait;
    logic w_in_xfer;
    logic w_full_load;
    logic w_load;

    assign w_output_wait = r_dout_valid & ~dout_ready;
    assign din_ready     = ~w_output_wait;
    assign w_in_xfer     = din_valid & din_ready;
    assign w_full_load   = w_in_xfer & ((r_state == S2) | (r_state == S4));

`ifdef EIGHT_TO_TWENTY_FLUSH_EN
    logic w_flush_take;
    logic r_dout_partial;

    // An input transfer has priority; flush in S0 has nothing to emit.
    assign w_flush_take = flush & ~w_in_xfer & ~w_output_wait & (r_state != S0);
    assign w_load       = w_full_load | w_flush_take;
    assign dout_partial = r_dout_partial;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_dout_partial <= 1'b0;
        end else if (w_load) begin
            r_dout_partial <= w_flush_take;
        end
    end
`else
    assign w_load = w_full_load;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= S0;
            r_hold       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                case (r_state)
                    S0: begin
                        // Upper half zeroed so unused hold words never show X.
                        r_hold  <= {{(8*W){1'b0}}, din};
                        r_state <= S1;
                    end
                    S1: begin
                        r_hold[16*W-1:8*W] <= din;
                        r_state            <= S2;
                    end
                    S2: begin
                        r_dout  <= {din[4*W-1:0], r_hold};
                        r_hold  <= {{(12*W){1'b0}}, din[8*W-1:4*W]};
                        r_state <= S3;
                    end
                    S3: begin
                        r_hold[12*W-1:4*W] <= din;
                        r_state            <= S4;
                    end
                    S4: begin
                        r_dout  <= {din, r_hold[12*W-1:0]};
                        r_hold  <= '0;
                        r_state <= S0;
                    end
                    default: begin
                        r_hold  <= '0;
                        r_state <= S0;
                    end
                endcase
            end
`ifdef EIGHT_TO_TWENTY_FLUSH_EN
            else if (w_flush_take) begin
                // Words above the held count are already zero in hold.
                r_dout  <= {{(4*W){1'b0}}, r_hold};
                r_hold  <= '0;
                r_state <= S0;
            end
`endif

            // A consume and a new load in the same cycle keep valid high.
            r_dout_valid <= w_load | (r_dout_valid & ~dout_ready);
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_eight_to_twenty.sv
module tb_eight_to_twenty;

    localparam int WL = 66;

    logic              clk;
    logic              arst_n;
    logic [8*WL-1:0]   din;
    logic              din_valid;
    logic              din_ready;
    logic [20*WL-1:0]  dout;
    logic              dout_valid;
    logic              dout_ready;
`ifdef EIGHT_TO_TWENTY_FLUSH_EN
    logic              flush;
    logic              dout_partial;
`endif

    eight_to_twenty #(.WORD_LEN(WL)) u_dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef EIGHT_TO_TWENTY_FLUSH_EN
        ,
        .flush        (flush),
        .dout_partial (dout_partial)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int next_word = 0;

    logic [WL-1:0]    word_q[$];
    logic [20*WL-1:0] exp_q[$];
    logic             part_q[$];

    task automatic chk(input string tag, input logic [WL-1:0] got, input logic [WL-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [WL-1:0] mk_word(input int n);
        logic [31:0] u;
        u = n;
        return {u ^ 32'hC3A5_5A3C, 2'b10, u};
    endfunction

    function automatic logic [8*WL-1:0] mk_beat(input int base);
        logic [8*WL-1:0] b;
        for (int k = 0; k < 8; k++) b[k*WL +: WL] = mk_word(base + k);
        return b;
    endfunction

    // One clock cycle: drive at negedge, check outputs, update model, advance.
    task automatic step(input logic v, input logic rdy, output logic acc);
        logic [20*WL-1:0] eb;
        logic             ep;
        logic             exp_valid;
        din_valid  = v;
        din        = mk_beat(next_word);
        dout_ready = rdy;
        #1;
        exp_valid = (exp_q.size() != 0);
        chk("dout_valid", WL'(dout_valid), WL'(exp_valid));
        chk("din_ready", WL'(din_ready), WL'(!(exp_valid && !rdy)));
        if (dout_valid && rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", WL'(1), WL'(0));
            end else begin
                eb = exp_q.pop_front();
                ep = part_q.pop_front();
                for (int k = 0; k < 20; k++) chk("dout_word", dout[k*WL +: WL], eb[k*WL +: WL]);
`ifdef EIGHT_TO_TWENTY_FLUSH_EN
                chk("dout_partial", WL'(dout_partial), WL'(ep));
`endif
            end
        end
        acc = v && din_ready;
        if (acc) begin
            for (int k = 0; k < 8; k++) word_q.push_back(mk_word(next_word + k));
            next_word += 8;
            while (word_q.size() >= 20) begin
                for (int k = 0; k < 20; k++) eb[k*WL +: WL] = word_q.pop_front();
                exp_q.push_back(eb);
                part_q.push_back(1'b0);
            end
        end
`ifdef EIGHT_TO_TWENTY_FLUSH_EN
        else if (flush && !(exp_valid && !rdy) && word_q.size() != 0) begin
            eb = '0;
            for (int k = 0; word_q.size() != 0; k++) eb[k*WL +: WL] = word_q.pop_front();
            exp_q.push_back(eb);
            part_q.push_back(1'b1);
        end
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int n, input logic rdy);
        int   got;
        logic acc;
        got = 0;
        for (int g = 0; g < n * 50 && got < n; g++) begin
            step(1'b1, rdy, acc);
            if (acc) got++;
        end
        chk("send_done", WL'(got), WL'(n));
    endtask

    task automatic drain();
        logic acc;
        for (int g = 0; g < 20 && exp_q.size() != 0; g++) step(1'b0, 1'b1, acc);
        chk("drain_empty", WL'(exp_q.size()), WL'(0));
    endtask

    task automatic do_reset();
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        arst_n     = 1'b0;
        #1;
        chk("rst_dout_valid", WL'(dout_valid), WL'(0));
        chk("rst_dout_zero", WL'(dout == '0), WL'(1));
        chk("rst_din_ready", WL'(din_ready), WL'(1));
`ifdef EIGHT_TO_TWENTY_FLUSH_EN
        chk("rst_dout_partial", WL'(dout_partial), WL'(0));
`endif
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        word_q.delete();
        exp_q.delete();
        part_q.delete();
        next_word = 0;
    endtask

    initial begin
        logic acc;
        int   got;
        arst_n     = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
`ifdef EIGHT_TO_TWENTY_FLUSH_EN
        flush      = 1'b0;
`endif
        @(negedge clk);
        do_reset();

        // 1: five beats -> two outputs
        send(5, 1'b1);
        drain();

        // 2: 50-beat continuous stream
        do_reset();
        send(50, 1'b1);
        drain();

        // 3: backpressure with a pending beat
        do_reset();
        send(3, 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (exp_q.size() != 0) chk("dout_stable", WL'(dout == exp_q[0]), WL'(1));
            step(1'b1, 1'b0, acc);
            chk("stall_no_accept", WL'(acc), WL'(0));
        end
        send(3, 1'b1);
        drain();

        // 4: reset mid-operation
        do_reset();
        send(4, 1'b1);
        #1;
        do_reset();
        next_word = 100;
        send(3, 1'b1);
        drain();

        // 5: random valid/ready
        do_reset();
        got = 0;
        for (int g = 0; g < 30000 && got < 1000; g++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
            if (acc) got++;
        end
        chk("rand_beats", WL'(got), WL'(1000));
        drain();

`ifdef EIGHT_TO_TWENTY_FLUSH_EN
        // 6: flush after one beat, then flush in S0
        do_reset();
        send(1, 1'b1);
        flush = 1'b1;
        step(1'b0, 1'b1, acc);
        flush = 1'b0;
        chk("flush_queued", WL'(exp_q.size()), WL'(1));
        step(1'b0, 1'b1, acc);
        flush = 1'b1;
        step(1'b0, 1'b1, acc);
        flush = 1'b0;
        step(1'b0, 1'b1, acc);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
